// File: rtl/uart_tx_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter.
//   tx_state_e      : transmitter FSM states (PARITY only used when
//                     UART_TX_PARITY_EN is defined)
//   ASCII_CR/LF     : line terminators written by the polling controller
//   CLK_FREQ_DEF    : default system clock frequency in Hz
//   BAUD_DEF        : default line rate in bit/s
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    START   = 3'd3,
    DATA    = 3'd4,
    PARITY  = 3'd5,
    STOP    = 3'd6
  } tx_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0d;
  localparam logic [7:0] ASCII_LF = 8'h0a;

  localparam int unsigned CLK_FREQ_DEF = 50_000_000;
  localparam int unsigned BAUD_DEF     = 115_200;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter for the UART transmitter.
// Counts 0..DIV-1 while enabled and wraps; clear forces it back to 0.
// Ports:
//   clk      : system clock
//   reset    : synchronous, active-high reset
//   clear    : return count to 0 (state entry)
//   enable   : advance the count
//   tick     : last cycle of the current bit period
//   tick_pre : second-to-last cycle of the bit period, lets the parent
//              register a pulse that lines up with the last cycle
module uart_baud_cnt #(
  parameter int unsigned DIV = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick,
  output logic tick_pre
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] PRE  = CW'(DIV - 2);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick     = enable && (count == LAST);
  assign tick_pre = enable && (count == PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// Reader end of the AD sample FIFO: pops one byte at a time (normal,
// non-show-ahead FIFO, q valid the cycle after rdreq) and sends it as an
// LSB-first UART frame on txd. Optional even parity bit when the macro
// UART_TX_PARITY_EN is defined (8E1, 11-bit frame); otherwise 8N1.
// Ports:
//   clk       : system clock
//   reset     : synchronous, active-high reset
//   empty     : FIFO empty flag
//   q         : FIFO read data
//   rdreq     : FIFO read request, one-cycle pulse per byte
//   txd       : UART serial output, idles high
//   busy      : high whenever the FSM is not in IDLE
//   byte_done : pulse on the last cycle of each stop bit
//   line_done : byte_done for a 0x0a byte
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | line high, waiting for empty=0
// RD_REQ  | rdreq asserted for this single cycle
// RD_WAIT | q now valid, latch it into shift/tx_byte
// START   | start bit (0) for BAUD_DIV cycles
// DATA    | 8 data bits LSB first, BAUD_DIV cycles each
// PARITY  | even parity bit (parity build only)
// STOP    | stop bit (1), byte_done on its last cycle
module fifo_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = CLK_FREQ_DEF,
  parameter int unsigned BAUD     = BAUD_DEF,
  parameter int unsigned BAUD_DIV = CLK_FREQ / BAUD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       empty,
  input  logic [7:0] q,
  output logic       rdreq,
  output logic       txd,
  output logic       busy,
  output logic       byte_done,
  output logic       line_done
);

  tx_state_e  state, state_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [7:0] shift, shift_nx;
  logic [7:0] tx_byte, tx_byte_nx;
  logic       txd_nx;
  logic       tick, tick_pre;
  logic       cnt_clear, cnt_enable;

  // Every state change restarts the bit period from zero.
  assign cnt_clear = (state_nx != state);

  always_comb begin
    cnt_enable = 1'b0;
    case (state)
      START, DATA, STOP: cnt_enable = 1'b1;
`ifdef UART_TX_PARITY_EN
      PARITY:            cnt_enable = 1'b1;
`endif
      default:           cnt_enable = 1'b0;
    endcase
  end

  uart_baud_cnt #(
    .DIV (BAUD_DIV)
  ) u_baud_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .tick     (tick),
    .tick_pre (tick_pre)
  );

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift;
    tx_byte_nx = tx_byte;
    case (state)
      IDLE: begin
        if (!empty) state_nx = RD_REQ;
      end
      RD_REQ: begin
        state_nx = RD_WAIT;
      end
      RD_WAIT: begin
        shift_nx   = q;
        tx_byte_nx = q;
        state_nx   = START;
      end
      START: begin
        if (tick) begin
          state_nx   = DATA;
          bit_cnt_nx = 3'd0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_nx = {1'b0, shift[7:1]};
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = STOP;
`endif
          end else begin
            bit_cnt_nx = bit_cnt + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) state_nx = STOP;
      end
`endif
      STOP: begin
        if (tick) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // txd is registered, so it is derived from the values the FSM is about
  // to enter rather than the current ones.
  always_comb begin
    txd_nx = 1'b1;
    case (state_nx)
      START:   txd_nx = 1'b0;
      DATA:    txd_nx = shift_nx[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_nx = ^tx_byte_nx;
`endif
      default: txd_nx = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift     <= 8'h00;
      tx_byte   <= 8'h00;
      txd       <= 1'b1;
      rdreq     <= 1'b0;
      busy      <= 1'b0;
      byte_done <= 1'b0;
      line_done <= 1'b0;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      shift     <= shift_nx;
      tx_byte   <= tx_byte_nx;
      txd       <= txd_nx;
      rdreq     <= (state_nx == RD_REQ);
      busy      <= (state_nx != IDLE);
      // tick_pre one cycle early makes the registered pulse land on the
      // final cycle of the stop bit.
      byte_done <= (state == STOP) && tick_pre;
      line_done <= (state == STOP) && tick_pre && (tx_byte == ASCII_LF);
    end
  end

endmodule
